// File: rtl/tree_sum_drain_pkg.sv
// Shared types and helpers for the adder-tree drain: latency derivation and the
// round/shift/saturate conversion applied to every tree sum.
package tree_drain_pkg;

  localparam int OUT_COUNT_W = 16;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] value;
  } sat_result_t;

  function automatic int latency_of(input int n);
    return $clog2(n);
  endfunction

  // Wide working width so the half-LSB bias can never wrap for any IN_WIDTH < 63.
  function automatic sat_result_t sat_round(input logic signed [63:0] value,
                                            input int shift,
                                            input int out_width);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_result_t        r;
    if (shift > 0) s = (value + (64'sd1 <<< (shift - 1))) >>> shift;
    else           s = value;
    hi      = (64'sd1 <<< (out_width - 1)) - 64'sd1;
    lo      = -hi - 64'sd1;
    r.sat   = 1'b0;
    r.value = s;
    if (s > hi) begin
      r.sat   = 1'b1;
      r.value = hi;
    end else if (s < lo) begin
      r.sat   = 1'b1;
      r.value = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/tree_sum_drain_if.sv
// Input acceptance and output valid/ready handshake of the tree drain.
interface tree_sum_drain_if #(
  parameter int OUT_WIDTH = 24
);
  logic                        in_valid;
  logic                        in_ready;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [OUT_WIDTH-1:0] out_data;

  modport master (
    output in_valid, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/tree_sum_drain_fifo.sv
// Small shift-style FIFO: entry 0 is always the registered head, so the output
// word comes straight from a flop and reads as zero after reset.
module drain_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] entries [DEPTH];
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    wr_idx;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign wr_idx   = do_pop ? count - CW'(1) : count;
  assign pop_data = entries[0];

  // A write lands after the shift, so push and pop in the same cycle keep order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      if (do_pop)
        for (int i = 0; i < DEPTH - 1; i++) entries[i] <= entries[i+1];
      if (do_push)
        for (int i = 0; i < DEPTH; i++)
          if (wr_idx == CW'(i)) entries[i] <= push_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tree_sum_drain.sv
// Drain for the signed adder tree: gates the tree clock enable, tracks valid sums,
// converts them to the narrow output word and buffers them behind valid/ready.
module tree_sum_drain
  import tree_drain_pkg::*;
#(
  parameter int N         = 32,
  parameter int IN_WIDTH  = 38,
  parameter int OUT_WIDTH = 24,
  parameter int SHIFT     = 8,
  parameter int DEPTH     = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  tree_sum_drain_if.slave              bus,
  output logic                         tree_ena,
  input  logic signed [IN_WIDTH-1:0]   tree_result,
  output logic                         overflow_sticky,
  input  logic                         overflow_clr,
  output logic [OUT_COUNT_W-1:0]       out_count
);
  localparam int LATENCY = latency_of(N);
  localparam int CW      = $clog2(DEPTH + 1);

  logic [LATENCY-1:0]   vsr;
  logic                 tail;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [CW-1:0]        fifo_count;
  logic [OUT_WIDTH-1:0] push_data;
  logic [OUT_WIDTH-1:0] head_data;
  sat_result_t          conv;

  assign tail         = vsr[LATENCY-1];
  assign tree_ena     = (fifo_count < CW'(DEPTH)) | ~tail;
  // Same as tree_ena & tail: a pending tail only ever waits on a full FIFO.
  assign push         = tail & ~full;
  assign pop          = bus.out_valid & bus.out_ready;
  assign bus.in_ready = tree_ena;
  assign bus.out_valid = ~empty;
  assign bus.out_data = head_data;

  always_comb begin
    conv      = sat_round({{(64-IN_WIDTH){tree_result[IN_WIDTH-1]}}, tree_result},
                          SHIFT, OUT_WIDTH);
    push_data = OUT_WIDTH'(conv.value);
  end

  // Valid bits march alongside the tree data and freeze with it when stalled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vsr <= '0;
    end else if (tree_ena) begin
      vsr[0] <= bus.in_valid;
      for (int i = 1; i < LATENCY; i++) vsr[i] <= vsr[i-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                  overflow_sticky <= 1'b0;
    else if (push && conv.sat)  overflow_sticky <= 1'b1;
    else if (overflow_clr)      overflow_sticky <= 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)    out_count <= '0;
    else if (pop) out_count <= out_count + OUT_COUNT_W'(1);
  end

  drain_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head_data),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: doc/tree_sum_drain.md
Name: tree_sum_drain

Overview:
- Downstream consumer of the signed adder-tree pipeline.
- Drives the tree's clock enable and tracks which tree outputs are valid.
- Rounds, shifts and saturates each valid tree sum to a narrower output word.
- Buffers results in a small FIFO with a valid/ready output handshake, so a stalled consumer freezes the tree instead of losing sums.

Parameters:
- N, 32, number of operands summed by the upstream tree; sets pipeline depth.
- IN_WIDTH, 38, tree result width (DATA_WIDTH 33 + clog2(32)).
- OUT_WIDTH, 24, output word width, signed.
- SHIFT, 8, arithmetic right shift applied with round-half-up; 0 = no shift, no rounding.
- DEPTH, 4, output FIFO entries, >= 2.
- LATENCY, $clog2(N), tree latency in enabled clock edges; derived, not overridden.

Ports:
- clock  in  1  single clock, shared with the tree.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  an operand vector is presented to the tree this cycle.
- in_ready  out  1  vector accepted at this edge when in_valid & in_ready; equals tree_ena.
- tree_ena  out  1  drives the tree's clock_ena.
- tree_result  in  IN_WIDTH  signed tree result.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head.
- out_data  out  OUT_WIDTH  signed rounded/saturated sum.
- overflow_sticky  out  1  set when any written result saturated.
- overflow_clr  in  1  clears overflow_sticky.
- out_count  out  16  results popped, wraps at 2^16.

Behaviour:
- Reset asserted (async): valid shift register (vsr, LATENCY bits) cleared and FIFO emptied.
- Also on reset: out_valid=0, out_data=0, overflow_sticky=0, out_count=0.
- Reset mid-operation: all in-flight and buffered results are discarded. Stale data inside the tree is ignored because vsr is clear.
- tail = vsr[LATENCY-1].
- tree_ena = (fifo_count < DEPTH) | ~tail. Combinational from registered state only; no path from out_ready.
- On each edge with tree_ena=1:
  - vsr shifts; vsr[0] <= in_valid.
  - If tail=1, the converted tree_result is written to the FIFO.
- tree_ena=0: vsr, tree and pending tail hold; no write; a tail result is written exactly once, at the next enabled edge.
- Latency:
  - Vector accepted at edge k, no stalls: written at edge k+LATENCY; out_valid high in the following cycle.
  - That is LATENCY+1 cycles; 6 for N=32.
- Conversion:
  - s = (tree_result + 2^(SHIFT-1)) >>> SHIFT, computed in IN_WIDTH+1 bits.
  - Saturate s to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - A saturated write sets overflow_sticky.
  - overflow_clr clears it; set wins when both occur on the same edge.
- FIFO:
  - Registered head, not fall-through.
  - Pop on out_valid & out_ready; out_count increments on each pop.
  - Simultaneous push and pop are legal at any occupancy; when full, a push only occurs alongside ~tail, i.e. never.
- Bubbles (in_valid=0) flow through the tree as garbage; they are never written.
- N=2 gives LATENCY=1. Non-power-of-2 N uses the same $clog2 latency because odd operands are registered passthrough.

Decomposition:
- Package tree_drain_pkg holds:
  - function latency_of(N) returning $clog2(N);
  - function sat_round(value, SHIFT, OUT_WIDTH);
  - localparam OUT_COUNT_W = 16.
- One sub-module, drain_fifo: synchronous DEPTH-entry FIFO with async active-high reset, push/pop/count/full/empty.
- Top level holds vsr, tree_ena logic, conversion and the sticky flag.

Test Plan:
- Single vector, tree_result=1000 at the tail, out_ready=1 -> out_valid pulses 6 cycles after acceptance, out_data=4, overflow_sticky=0.
- tree_result=-384 -> out_data=-1 (round half up of -1.5). tree_result=-385 -> out_data=-2.
- tree_result=2^37-1 -> out_data=8388607, overflow_sticky=1. Then overflow_clr=1 with no overflow -> sticky=0.
- Continuous in_valid, out_ready=0:
  - 4 results fill the FIFO; tree_ena drops when the 5th reaches the tail.
  - out_ready=1 then drains 5 results in order with no loss or duplicate; out_count=5.
- Alternating in_valid 1/0 with random out_ready stalls over 200 vectors -> output sequence equals the model sequence exactly.
- Reset asserted mid-stream with 3 vectors in flight and 2 buffered -> out_valid=0 immediately; no stale result after release; out_count=0.
